// File: rtl/reg_write_sequencer.sv
// Host-side sequencer for the per-bit register bank. It decodes the address to a one-hot
// select, times an active-low write strobe, captures read-back data and returns one response.
module reg_write_sequencer #(
  parameter int BUS_WIDTH  = 15,
  parameter int NUM_REGS   = 31,
  parameter int ADDR_W     = 5,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [BUS_WIDTH:0]  req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [BUS_WIDTH:0]  resp_rdata,
  output logic                resp_err,
  output logic [NUM_REGS-1:0] reg_sel,
  output logic                wrb,
  output logic [BUS_WIDTH:0]  reg_din,
  input  logic [BUS_WIDTH:0]  reg_rdout
);

  localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0]  SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]  STROBE_LD  = CNT_W'(STROBE_CYC - 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_t;

  state_t                r_state;
  state_t                w_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_accept;
  logic                  w_addr_ok;
  logic [NUM_REGS-1:0]   w_sel_dec;

  logic                  r_ready;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [BUS_WIDTH:0]    r_resp_rdata;
  logic [NUM_REGS-1:0]   r_sel;
  logic                  r_wrb;
  logic [BUS_WIDTH:0]    r_din;
  logic                  r_write;

  assign w_addr_ok = ({1'b0, req_addr} < ADDR_LIMIT);
  assign w_sel_dec = {{(NUM_REGS-1){1'b0}}, 1'b1} << req_addr;

  // Next-state logic; r_cnt counts down the remaining cycles of SETUP and STROBE.
  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_ready) begin
          w_accept = 1'b1;
          w_nxt    = w_addr_ok ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP:  if (r_cnt == '0) w_nxt = ST_STROBE;
      ST_STROBE: if (r_cnt == '0) w_nxt = ST_HOLD;
      ST_HOLD:   w_nxt = ST_RESP;
      ST_RESP:   if (resp_ready) w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state) begin
        case (w_nxt)
          ST_SETUP:  r_cnt <= SETUP_LD;
          ST_STROBE: r_cnt <= STROBE_LD;
          default:   r_cnt <= '0;
        endcase
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Every bank-facing and host-facing output is a flop driven from the next state,
  // so wrb cannot glitch and reg_sel changes only on clock edges.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_sel        <= '0;
      r_wrb        <= 1'b1;
      r_din        <= '0;
      r_write      <= 1'b0;
    end else begin
      r_ready      <= (w_nxt == ST_IDLE);
      r_resp_valid <= (w_nxt == ST_RESP);
      r_wrb        <= !((w_nxt == ST_STROBE) && r_write);
      if (w_accept) begin
        r_write      <= req_write;
        r_resp_rdata <= '0;
        if (w_addr_ok) begin
          r_sel <= w_sel_dec;
          r_din <= req_wdata;
        end else begin
          r_resp_err <= 1'b1;
        end
      end
      if (w_nxt == ST_RESP) r_sel <= '0;
      if ((r_state == ST_STROBE) && (r_cnt == '0) && !r_write) r_resp_rdata <= reg_rdout;
      if ((r_state == ST_RESP) && resp_ready) begin
        r_resp_err   <= 1'b0;
        r_resp_rdata <= '0;
      end
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign reg_sel    = r_sel;
  assign wrb        = r_wrb;
  assign reg_din    = r_din;

endmodule
